// File: rtl/multilane_match_length.sv
// multilane_match_length: multi-lane dictionary match plus length generation
// front end for the cache-line compressor. Each beat carries LANES words. Every
// word is classified against a per-line FIFO dictionary. A two-stage pipeline
// (S1 match, S2 length/accumulate) produces per-lane code, index and length,
// and keeps running line bit totals with a sticky overflow flag.
//
// Optional build macro: INTRA_BEAT_FWD_EN. When it is defined, each lane also
// sees the words pushed by lower lanes of the same beat, which gives the same
// result as processing the words one at a time. The default build has no
// forwarding, so every lane sees the dictionary as it was before the beat.
module multilane_match_length #(
    parameter int LANES      = 2,
    parameter int WORD       = 32,
    parameter int DICT_ENTRY = 16,
    parameter int CACHE_LINE = 128
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic [LANES*WORD-1:0]                 i_word,
    input  logic                                  i_last,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [LANES*3-1:0]                    o_code,
    output logic [LANES*$clog2(DICT_ENTRY)-1:0]   o_index,
    output logic [LANES*6-1:0]                    o_length,
    output logic [7:0]                            o_total_length,
    output logic [15:0]                           o_line_bits,
    output logic                                  o_line_done,
    output logic                                  o_overflow,
    output logic [LANES*WORD-1:0]                 o_word
);

    localparam int IDX_W = $clog2(DICT_ENTRY);

    localparam logic [2:0] CODE_ZZZZ = 3'd0;
    localparam logic [2:0] CODE_XXXX = 3'd1;
    localparam logic [2:0] CODE_MMMM = 3'd2;
    localparam logic [2:0] CODE_MMXX = 3'd3;
    localparam logic [2:0] CODE_ZZZX = 3'd4;
    localparam logic [2:0] CODE_MMMX = 3'd5;

    localparam logic [5:0] LEN_ZZZZ = 6'd2;
    localparam logic [5:0] LEN_ZZZX = 6'd12;
    localparam logic [5:0] LEN_MMMM = 6'(2 + IDX_W);
    localparam logic [5:0] LEN_MMMX = 6'(4 + IDX_W + 8);
    localparam logic [5:0] LEN_MMXX = 6'(4 + IDX_W + 16);
    localparam logic [5:0] LEN_XXXX = 6'(2 + WORD);

    localparam logic [15:0] LINE_LIMIT = 16'(CACHE_LINE);

    // Dictionary state
    logic [WORD-1:0]       dict_data [DICT_ENTRY];
    logic [DICT_ENTRY-1:0] dict_valid;
    logic [IDX_W-1:0]      wr_ptr;

    // Dictionary contents after this beat's pushes, and per-lane match results
    logic [WORD-1:0]        next_data [DICT_ENTRY];
    logic [DICT_ENTRY-1:0]  next_valid;
    logic [IDX_W-1:0]       next_ptr;
    logic [LANES*3-1:0]     m_code;
    logic [LANES*IDX_W-1:0] m_index;

    // Handshake
    logic advance;
    logic accept;

    // Stage 1 registers
    logic                   s1_valid;
    logic [LANES*3-1:0]     s1_code;
    logic [LANES*IDX_W-1:0] s1_index;
    logic [LANES*WORD-1:0]  s1_word;
    logic                   s1_last;

    // Stage 2 next values
    logic [LANES*6-1:0] s1_length;
    logic [7:0]         s1_total;
    logic [15:0]        bits_next;
    logic               ovf_next;

    assign advance = !o_valid || i_ready;
    assign accept  = i_valid && advance;
    assign o_ready = advance;

    // Classify each lane in lane order and build the post-beat dictionary view.
    // Lowest index wins because the entry scan runs downward and the last hit
    // sticks.
    always_comb begin : match_logic
        logic [WORD-1:0]  w;
        logic [WORD-1:0]  cmp_data;
        logic             cmp_valid;
        logic             full_hit;
        logic             hi_hit;
        logic             mid_hit;
        logic [IDX_W-1:0] full_idx;
        logic [IDX_W-1:0] hi_idx;
        logic [IDX_W-1:0] mid_idx;
        logic [2:0]       code;
        logic [IDX_W-1:0] idx;

        next_data  = dict_data;
        next_valid = dict_valid;
        next_ptr   = wr_ptr;
        m_code     = '0;
        m_index    = '0;
        w          = '0;
        cmp_data   = '0;
        cmp_valid  = 1'b0;
        full_hit   = 1'b0;
        hi_hit     = 1'b0;
        mid_hit    = 1'b0;
        full_idx   = '0;
        hi_idx     = '0;
        mid_idx    = '0;
        code       = CODE_XXXX;
        idx        = '0;

        for (int k = 0; k < LANES; k++) begin
            w        = i_word[k*WORD +: WORD];
            full_hit = 1'b0;
            hi_hit   = 1'b0;
            mid_hit  = 1'b0;
            full_idx = '0;
            hi_idx   = '0;
            mid_idx  = '0;

            for (int i = DICT_ENTRY - 1; i >= 0; i--) begin
`ifdef INTRA_BEAT_FWD_EN
                cmp_valid = next_valid[i];
                cmp_data  = next_data[i];
`else
                cmp_valid = dict_valid[i];
                cmp_data  = dict_data[i];
`endif
                if (cmp_valid && (cmp_data == w)) begin
                    full_hit = 1'b1;
                    full_idx = IDX_W'(i);
                end
                if (cmp_valid && (cmp_data[WORD-1:8] == w[WORD-1:8])) begin
                    hi_hit = 1'b1;
                    hi_idx = IDX_W'(i);
                end
                if (cmp_valid && (cmp_data[WORD-1:16] == w[WORD-1:16])) begin
                    mid_hit = 1'b1;
                    mid_idx = IDX_W'(i);
                end
            end

            if (w == '0) begin
                code = CODE_ZZZZ;
                idx  = '0;
            end else if (w[WORD-1:8] == '0) begin
                code = CODE_ZZZX;
                idx  = '0;
            end else if (full_hit) begin
                code = CODE_MMMM;
                idx  = full_idx;
            end else if (hi_hit) begin
                code = CODE_MMMX;
                idx  = hi_idx;
            end else if (mid_hit) begin
                code = CODE_MMXX;
                idx  = mid_idx;
            end else begin
                code = CODE_XXXX;
                idx  = '0;
            end

            m_code[k*3 +: 3]         = code;
            m_index[k*IDX_W +: IDX_W] = idx;

            if ((code == CODE_XXXX) || (code == CODE_MMXX) || (code == CODE_MMMX)) begin
                next_data[next_ptr]  = w;
                next_valid[next_ptr] = 1'b1;
                next_ptr             = next_ptr + IDX_W'(1);
            end
        end
    end

    // Commit valid bits and write pointer once per accepted beat; a line's last beat clears them
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            dict_valid <= '0;
            wr_ptr     <= '0;
        end else if (accept) begin
            if (i_last) begin
                dict_valid <= '0;
                wr_ptr     <= '0;
            end else begin
                dict_valid <= next_valid;
                wr_ptr     <= next_ptr;
            end
        end
    end

    // Store pushed words; entries are qualified by dict_valid so the data needs no reset
    always_ff @(posedge i_clk) begin
        if (i_reset && accept && !i_last) begin
            dict_data <= next_data;
        end
    end

    // Stage 1: capture match results alongside the raw beat
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_index <= '0;
            s1_word  <= '0;
            s1_last  <= 1'b0;
        end else if (advance) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_code  <= m_code;
                s1_index <= m_index;
                s1_word  <= i_word;
                s1_last  <= i_last;
            end
        end
    end

    // Map codes to lengths and work out the line totals that stage 2 will load
    always_comb begin : length_logic
        logic [5:0] len;

        s1_length = '0;
        s1_total  = '0;
        len       = LEN_XXXX;
        for (int k = 0; k < LANES; k++) begin
            case (s1_code[k*3 +: 3])
                CODE_ZZZZ: len = LEN_ZZZZ;
                CODE_ZZZX: len = LEN_ZZZX;
                CODE_MMMM: len = LEN_MMMM;
                CODE_MMMX: len = LEN_MMMX;
                CODE_MMXX: len = LEN_MMXX;
                default:   len = LEN_XXXX;
            endcase
            s1_length[k*6 +: 6] = len;
            s1_total            = s1_total + 8'(len);
        end

        if (o_line_done) begin
            bits_next = {8'd0, s1_total};
            ovf_next  = (bits_next > LINE_LIMIT);
        end else begin
            bits_next = o_line_bits + {8'd0, s1_total};
            ovf_next  = o_overflow || (bits_next > LINE_LIMIT);
        end
    end

    // Stage 2: output register; holds its contents across bubbles so line totals carry on
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_valid        <= 1'b0;
            o_code         <= '0;
            o_index        <= '0;
            o_length       <= '0;
            o_total_length <= '0;
            o_line_bits    <= '0;
            o_line_done    <= 1'b0;
            o_overflow     <= 1'b0;
            o_word         <= '0;
        end else if (advance) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_code         <= s1_code;
                o_index        <= s1_index;
                o_length       <= s1_length;
                o_total_length <= s1_total;
                o_line_bits    <= bits_next;
                o_line_done    <= s1_last;
                o_overflow     <= ovf_next;
                o_word         <= s1_word;
            end
        end
    end

endmodule
